// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone single-master interconnect.
package wb_pkg;

  // Transaction FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Response kind presented to the master during RESP
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_ACK  = 2'd1,
    RSP_ERR  = 2'd2,
    RSP_RTY  = 2'd3
  } rsp_e;

  // Default number of stalled WAIT cycles before a bus error is forced
  localparam int unsigned DEFAULT_TIMEOUT = 16;

  // 16-bit increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational address decoder: one-hot hit vector (lowest slave wins on overlap) plus miss flag.
module wb_addr_decoder #(
  parameter int unsigned                NUM_SLAVES     = 3,
  parameter logic [32*NUM_SLAVES-1:0]   BASE_ADDRESSES = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
  parameter logic [32*NUM_SLAVES-1:0]   SIZES          = {32'h1000, 32'h4000, 32'h20_0000}
) (
  input  logic [31:0]           adr_i,
  output logic [NUM_SLAVES-1:0] hit_o,
  output logic                  miss_o
);

  logic [NUM_SLAVES-1:0] match;

  // Windows are power-of-two sized and aligned, so a mask compare is enough
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
    localparam logic [31:0] BASE = BASE_ADDRESSES[gi*32 +: 32];
    localparam logic [31:0] MASK = ~(SIZES[gi*32 +: 32] - 32'd1);
    assign match[gi] = ((adr_i & MASK) == BASE);
  end

  // Keep only the lowest-numbered matching window
  always_comb begin
    logic found;
    hit_o = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (match[k] && !found) begin
        hit_o[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign miss_o = ~|match;

endmodule

// File: rtl/wb_interconnect.sv
// Single-master, multi-slave Wishbone interconnect with address decode,
// registered request/response paths, stall timeout and status counters.
module wb_interconnect
  import wb_pkg::*;
#(
  parameter int unsigned              NUM_SLAVES     = 3,
  parameter logic [32*NUM_SLAVES-1:0] BASE_ADDRESSES = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
  parameter logic [32*NUM_SLAVES-1:0] SIZES          = {32'h1000, 32'h4000, 32'h20_0000},
  parameter int unsigned              TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     m_cyc_i,
  input  logic                     m_stb_i,
  input  logic [31:0]              m_adr_i,
  input  logic [3:0]               m_sel_i,
  input  logic                     m_we_i,
  input  logic [31:0]              m_dat_i,
  output logic [31:0]              m_dat_o,
  output logic                     m_ack_o,
  output logic                     m_err_o,
  output logic                     m_rty_o,
  output logic [NUM_SLAVES-1:0]    s_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  output logic [31:0]              s_adr_o,
  output logic [3:0]               s_sel_o,
  output logic                     s_we_o,
  output logic [31:0]              s_dat_o,
  input  logic [32*NUM_SLAVES-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  input  logic [NUM_SLAVES-1:0]    s_err_i,
  input  logic [NUM_SLAVES-1:0]    s_rty_i,
  output logic [15:0]              timeout_count_o,
  output logic [15:0]              decode_miss_count_o
);

  // Value of the WAIT counter in the last cycle a slave may still answer
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  rsp_e                  rsp_q, rsp_d;
  logic [NUM_SLAVES-1:0] grant_q, grant_d;
  logic [NUM_SLAVES-1:0] s_req_q, s_req_d;
  logic [15:0]           wait_cnt_q, wait_cnt_d;
  logic [15:0]           tmo_cnt_q, tmo_cnt_d;
  logic [15:0]           miss_cnt_q, miss_cnt_d;
  logic [31:0]           m_dat_q, m_dat_d;
  logic [31:0]           s_adr_q, s_adr_d;
  logic [31:0]           s_dat_q, s_dat_d;
  logic [3:0]            s_sel_q, s_sel_d;
  logic                  s_we_q, s_we_d;

  logic [NUM_SLAVES-1:0] dec_hit;
  logic                  dec_miss;
  logic [31:0]           gnt_dat;
  logic                  gnt_ack, gnt_err, gnt_rty;

  wb_addr_decoder #(
    .NUM_SLAVES     (NUM_SLAVES),
    .BASE_ADDRESSES (BASE_ADDRESSES),
    .SIZES          (SIZES)
  ) u_dec (
    .adr_i  (m_adr_i),
    .hit_o  (dec_hit),
    .miss_o (dec_miss)
  );

  // Only the granted slave's response lines and data are ever looked at
  assign gnt_ack = |(s_ack_i & grant_q);
  assign gnt_err = |(s_err_i & grant_q);
  assign gnt_rty = |(s_rty_i & grant_q);

  // AND-OR mux of the granted slave's read data
  always_comb begin
    gnt_dat = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (grant_q[k]) gnt_dat = s_dat_i[k*32 +: 32];
    end
  end

  // Next-state and next-output computation for the transaction FSM
  always_comb begin
    state_d    = state_q;
    rsp_d      = RSP_NONE;
    grant_d    = grant_q;
    s_req_d    = s_req_q;
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    miss_cnt_d = miss_cnt_q;
    m_dat_d    = m_dat_q;
    s_adr_d    = s_adr_q;
    s_dat_d    = s_dat_q;
    s_sel_d    = s_sel_q;
    s_we_d     = s_we_q;

    case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          if (dec_miss) begin
            state_d    = RESP;
            rsp_d      = RSP_ERR;
            m_dat_d    = '0;
            miss_cnt_d = sat_inc16(miss_cnt_q);
          end else begin
            state_d    = WAIT;
            grant_d    = dec_hit;
            s_req_d    = dec_hit;
            wait_cnt_d = '0;
            s_adr_d    = m_adr_i;
            s_dat_d    = m_dat_i;
            s_sel_d    = m_sel_i;
            s_we_d     = m_we_i;
          end
        end
      end

      WAIT: begin
        if (!m_cyc_i) begin
          // Master abandoned the cycle: release the slave silently
          state_d = IDLE;
          s_req_d = '0;
        end else if (gnt_ack) begin
          state_d = RESP;
          rsp_d   = RSP_ACK;
          m_dat_d = gnt_dat;
          s_req_d = '0;
        end else if (gnt_err || gnt_rty) begin
          state_d = RESP;
          rsp_d   = gnt_err ? RSP_ERR : RSP_RTY;
          m_dat_d = '0;
          s_req_d = '0;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d   = RESP;
          rsp_d     = RSP_ERR;
          m_dat_d   = '0;
          s_req_d   = '0;
          tmo_cnt_d = sat_inc16(tmo_cnt_q);
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        s_req_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      rsp_q      <= RSP_NONE;
      grant_q    <= '0;
      s_req_q    <= '0;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      miss_cnt_q <= '0;
      m_dat_q    <= '0;
      s_adr_q    <= '0;
      s_dat_q    <= '0;
      s_sel_q    <= '0;
      s_we_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_q      <= rsp_d;
      grant_q    <= grant_d;
      s_req_q    <= s_req_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      m_dat_q    <= m_dat_d;
      s_adr_q    <= s_adr_d;
      s_dat_q    <= s_dat_d;
      s_sel_q    <= s_sel_d;
      s_we_q     <= s_we_d;
    end
  end

  assign m_ack_o             = (rsp_q == RSP_ACK);
  assign m_err_o             = (rsp_q == RSP_ERR);
  assign m_rty_o             = (rsp_q == RSP_RTY);
  assign m_dat_o             = m_dat_q;
  assign s_cyc_o             = s_req_q;
  assign s_stb_o             = s_req_q;
  assign s_adr_o             = s_adr_q;
  assign s_sel_o             = s_sel_q;
  assign s_we_o              = s_we_q;
  assign s_dat_o             = s_dat_q;
  assign timeout_count_o     = tmo_cnt_q;
  assign decode_miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_wb_interconnect.sv
// Self-checking bench for wb_interconnect: directed scenarios plus randomized
// traffic compared against a cycle-count/priority reference model.
module tb_wb_interconnect;

  localparam int NS  = 3;
  localparam int TMO = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              m_cyc_i, m_stb_i, m_we_i;
  logic [31:0]       m_adr_i, m_dat_i;
  logic [3:0]        m_sel_i;
  logic [31:0]       m_dat_o;
  logic              m_ack_o, m_err_o, m_rty_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o;
  logic [32*NS-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i, s_err_i, s_rty_i;
  logic [15:0]       timeout_count_o, decode_miss_count_o;

  int checks   = 0;
  int failures = 0;
  int exp_tmo  = 0;
  int exp_miss = 0;

  logic [31:0] base_tab [NS] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
  logic [31:0] size_tab [NS] = '{32'h0020_0000, 32'h0000_4000, 32'h0000_1000};

  wb_interconnect #(
    .NUM_SLAVES     (NS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .m_cyc_i             (m_cyc_i),
    .m_stb_i             (m_stb_i),
    .m_adr_i             (m_adr_i),
    .m_sel_i             (m_sel_i),
    .m_we_i              (m_we_i),
    .m_dat_i             (m_dat_i),
    .m_dat_o             (m_dat_o),
    .m_ack_o             (m_ack_o),
    .m_err_o             (m_err_o),
    .m_rty_o             (m_rty_o),
    .s_cyc_o             (s_cyc_o),
    .s_stb_o             (s_stb_o),
    .s_adr_o             (s_adr_o),
    .s_sel_o             (s_sel_o),
    .s_we_o              (s_we_o),
    .s_dat_o             (s_dat_o),
    .s_dat_i             (s_dat_i),
    .s_ack_i             (s_ack_i),
    .s_err_i             (s_err_i),
    .s_rty_i             (s_rty_i),
    .timeout_count_o     (timeout_count_o),
    .decode_miss_count_o (decode_miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  // One master transaction. lat = WAIT cycles before the slave answers (-1 = never).
  // rsp_bits = {rty, err, ack} driven together by the target slave.
  // keep = leave the request asserted for a back-to-back follow-up;
  // after_b2b = this call follows a kept request (one extra IDLE cycle first).
  task automatic do_txn(input string tag, input logic [31:0] adr, input logic we,
                        input logic [31:0] wdat, input logic [3:0] sel, input int lat,
                        input logic [2:0] rsp_bits, input logic [31:0] rdat,
                        input logic [NS-1:0] spur, input bit keep, input bit after_b2b);
    int          tgt;
    int          exp_cyc;
    int          got_cyc;
    int          stb_cnt;
    int          shift;
    bit          seen;
    logic [2:0]  exp_flags;
    logic [31:0] exp_dat;
    logic [NS-1:0] exp_oh;
    logic [NS-1:0] spur_eff;

    // Reference model: window lookup by range, then latency/kind from the rules
    shift = after_b2b ? 1 : 0;
    tgt = -1;
    for (int k = NS - 1; k >= 0; k--) begin
      if (adr >= base_tab[k] && (adr - base_tab[k]) < size_tab[k]) tgt = k;
    end
    exp_oh = '0;
    if (tgt < 0) begin
      exp_cyc   = 1;
      exp_flags = 3'b010;
      if (exp_miss < 65535) exp_miss++;
    end else begin
      exp_oh[tgt] = 1'b1;
      if (lat >= 0 && lat < TMO && rsp_bits != 3'b000) begin
        exp_cyc = lat + 2;
        if (rsp_bits[0])      exp_flags = 3'b100;
        else if (rsp_bits[1]) exp_flags = 3'b010;
        else                  exp_flags = 3'b001;
      end else begin
        exp_cyc   = TMO + 1;
        exp_flags = 3'b010;
        if (exp_tmo < 65535) exp_tmo++;
      end
    end
    exp_dat  = (exp_flags == 3'b100) ? rdat : 32'h0;
    exp_cyc  = exp_cyc + shift;
    spur_eff = spur & ~exp_oh;

    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = adr; m_we_i = we; m_dat_i = wdat; m_sel_i = sel;
    for (int k = 0; k < NS; k++) s_dat_i[k*32 +: 32] = $urandom;
    s_ack_i = spur_eff; s_err_i = spur_eff; s_rty_i = '0;

    seen = 0; got_cyc = 0; stb_cnt = 0;
    for (int c = 1; c <= TMO + 8 && !seen; c++) begin
      @(negedge clk_i);
      if (s_stb_o != '0) begin
        stb_cnt++;
        checks++;
        if (s_stb_o !== exp_oh || s_cyc_o !== exp_oh) begin
          failures++;
          $display("FAIL %s strobe: got stb=%b cyc=%b expected %b", tag, s_stb_o, s_cyc_o, exp_oh);
        end
        checks++;
        if ({s_adr_o, s_sel_o, s_we_o, s_dat_o} !== {adr, sel, we, wdat}) begin
          failures++;
          $display("FAIL %s slave_req: got adr=%h sel=%b we=%b dat=%h expected adr=%h sel=%b we=%b dat=%h",
                   tag, s_adr_o, s_sel_o, s_we_o, s_dat_o, adr, sel, we, wdat);
        end
      end
      if (m_ack_o || m_err_o || m_rty_o) begin
        seen    = 1;
        got_cyc = c;
      end else begin
        s_ack_i = spur_eff; s_err_i = spur_eff; s_rty_i = '0;
        if (tgt >= 0 && lat == c - 1 - shift) begin
          s_ack_i[tgt] = rsp_bits[0];
          s_err_i[tgt] = rsp_bits[1];
          s_rty_i[tgt] = rsp_bits[2];
          s_dat_i[tgt*32 +: 32] = rdat;
        end
      end
    end

    checks++;
    if (!seen || got_cyc != exp_cyc) begin
      failures++;
      $display("FAIL %s latency: got cycle %0d (seen=%0d) expected cycle %0d", tag, got_cyc, seen, exp_cyc);
    end
    if (seen) begin
      checks++;
      if ({m_ack_o, m_err_o, m_rty_o} !== exp_flags) begin
        failures++;
        $display("FAIL %s resp_kind: got ack/err/rty=%b expected %b", tag, {m_ack_o, m_err_o, m_rty_o}, exp_flags);
      end
      checks++;
      if (m_dat_o !== exp_dat) begin
        failures++;
        $display("FAIL %s m_dat: got %h expected %h", tag, m_dat_o, exp_dat);
      end
      checks++;
      if (s_stb_o !== '0 || s_cyc_o !== '0) begin
        failures++;
        $display("FAIL %s resp_strobe: got stb=%b cyc=%b expected 0", tag, s_stb_o, s_cyc_o);
      end
    end
    checks++;
    if (stb_cnt != exp_cyc - 1 - shift) begin
      failures++;
      $display("FAIL %s strobe_cycles: got %0d expected %0d", tag, stb_cnt, exp_cyc - 1 - shift);
    end
    checks++;
    if (timeout_count_o !== 16'(exp_tmo) || decode_miss_count_o !== 16'(exp_miss)) begin
      failures++;
      $display("FAIL %s counters: got tmo=%0d miss=%0d expected tmo=%0d miss=%0d",
               tag, timeout_count_o, decode_miss_count_o, exp_tmo, exp_miss);
    end

    s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
    if (!keep) begin
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (m_ack_o || m_err_o || m_rty_o) begin
        failures++;
        $display("FAIL %s resp_pulse: got ack/err/rty=%b one cycle after response expected 000",
                 tag, {m_ack_o, m_err_o, m_rty_o});
      end
    end
    $display("txn %s adr=%h we=%0d slave=%0d flags=%b dat=%h cycles=%0d", tag, adr, we, tgt,
             {m_ack_o, m_err_o, m_rty_o}, exp_dat, got_cyc);
  endtask

  task automatic idle_inputs();
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_dat_i = '0; s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk_i);
    checks++;
    if ({m_ack_o, m_err_o, m_rty_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_resp: got %b expected 000", {m_ack_o, m_err_o, m_rty_o});
    end
    checks++;
    if (m_dat_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_mdat: got %h expected 0", m_dat_o);
    end
    checks++;
    if (s_cyc_o !== '0 || s_stb_o !== '0) begin
      failures++;
      $display("FAIL reset_strobe: got cyc=%b stb=%b expected 0", s_cyc_o, s_stb_o);
    end
    checks++;
    if ({s_adr_o, s_sel_o, s_we_o, s_dat_o} !== '0) begin
      failures++;
      $display("FAIL reset_slave_bus: got adr=%h sel=%b we=%b dat=%h expected 0", s_adr_o, s_sel_o, s_we_o, s_dat_o);
    end
    checks++;
    if (timeout_count_o !== 16'h0 || decode_miss_count_o !== 16'h0) begin
      failures++;
      $display("FAIL reset_counters: got tmo=%0d miss=%0d expected 0", timeout_count_o, decode_miss_count_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_abort();
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h3000_0008; m_we_i = 1'b0; m_sel_i = 4'hF;
    s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
    @(negedge clk_i);
    checks++;
    if (s_stb_o !== 3'b100) begin
      failures++;
      $display("FAIL abort_strobe: got %b expected 100", s_stb_o);
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (s_stb_o !== '0 || s_cyc_o !== '0 || {m_ack_o, m_err_o, m_rty_o} !== 3'b000) begin
      failures++;
      $display("FAIL abort_release: got stb=%b cyc=%b resp=%b expected 0", s_stb_o, s_cyc_o,
               {m_ack_o, m_err_o, m_rty_o});
    end
    s_ack_i = 3'b100;
    @(negedge clk_i);
    checks++;
    if ({m_ack_o, m_err_o, m_rty_o} !== 3'b000 || timeout_count_o !== 16'(exp_tmo) ||
        decode_miss_count_o !== 16'(exp_miss)) begin
      failures++;
      $display("FAIL abort_quiet: got resp=%b tmo=%0d miss=%0d expected 000 tmo=%0d miss=%0d",
               {m_ack_o, m_err_o, m_rty_o}, timeout_count_o, decode_miss_count_o, exp_tmo, exp_miss);
    end
    s_ack_i = '0;
    $display("txn abort adr=30000008 released without response");
  endtask

  task automatic test_reset_mid_wait();
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h2000_0020; m_we_i = 1'b1;
    m_dat_i = 32'hA5A5_5A5A; m_sel_i = 4'hF;
    @(negedge clk_i);
    checks++;
    if (s_stb_o !== 3'b010) begin
      failures++;
      $display("FAIL rstwait_strobe: got %b expected 010", s_stb_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({m_ack_o, m_err_o, m_rty_o, m_dat_o, s_cyc_o, s_stb_o, s_adr_o, s_sel_o, s_we_o, s_dat_o,
         timeout_count_o, decode_miss_count_o} !== '0) begin
      failures++;
      $display("FAIL rstwait_outputs: got resp=%b mdat=%h stb=%b adr=%h dat=%h tmo=%0d miss=%0d expected all 0",
               {m_ack_o, m_err_o, m_rty_o}, m_dat_o, s_stb_o, s_adr_o, s_dat_o, timeout_count_o,
               decode_miss_count_o);
    end
    exp_tmo  = 0;
    exp_miss = 0;
    rst_i = 1'b1; m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge clk_i);
    $display("txn reset_mid_wait adr=20000020 cleared");
    do_txn("after_reset", 32'h2000_0024, 1'b0, 32'h0, 4'hF, 1, 3'b001, 32'hCAFE_F00D, '0, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_txn("b2b_a", 32'h3000_0010, 1'b0, 32'h0, 4'hF, 0, 3'b001, 32'h1111_2222, '0, 1, 0);
    do_txn("b2b_b", 32'h2000_0030, 1'b1, 32'h3333_4444, 4'h3, 0, 3'b001, 32'h0, '0, 1, 1);
    do_txn("b2b_c", 32'h5000_0000, 1'b0, 32'h0, 4'hF, 0, 3'b001, 32'h0, '0, 0, 1);
  endtask

  task automatic test_random();
    bit          prev_keep;
    bit          keep;
    int          r;
    int          k;
    int          lat;
    logic [31:0] adr;
    prev_keep = 0;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      adr = 32'h4000_0000 | ($urandom & 32'h00FF_FFFC);
      else if (r == 1) adr = 32'h1020_0000 + 32'($urandom_range(0, 255) * 4);
      else begin
        k   = $urandom_range(0, NS - 1);
        adr = base_tab[k] + ($urandom & (size_tab[k] - 32'd1));
      end
      r = $urandom_range(0, 9);
      if (r == 0)      lat = -1;
      else if (r == 1) lat = TMO - 1;
      else if (r == 2) lat = TMO;
      else             lat = $urandom_range(0, 6);
      keep = (n < 39) && ($urandom_range(0, 2) == 0);
      do_txn("rand", adr, 1'($urandom), $urandom, 4'($urandom), lat, 3'($urandom_range(1, 7)),
             $urandom, NS'($urandom), keep, prev_keep);
      prev_keep = keep;
    end
  endtask

  initial begin
    test_reset();
    do_txn("read_zero_wait", 32'h2000_0010, 1'b0, 32'h0, 4'hF, 0, 3'b001, 32'hDEAD_BEEF, '0, 0, 0);
    do_txn("write", 32'h1000_0004, 1'b1, 32'h1234_5678, 4'b1100, 1, 3'b001, 32'h0, '0, 0, 0);
    do_txn("decode_miss", 32'h4000_0000, 1'b0, 32'h0, 4'hF, 0, 3'b001, 32'h0, 3'b111, 0, 0);
    do_txn("timeout", 32'h1000_0100, 1'b0, 32'h0, 4'hF, -1, 3'b000, 32'h0, '0, 0, 0);
    do_txn("last_wait_ack", 32'h3000_0040, 1'b0, 32'h0, 4'hF, TMO - 1, 3'b001, 32'h0BAD_CAFE, '0, 0, 0);
    do_txn("late_ack", 32'h3000_0044, 1'b0, 32'h0, 4'hF, TMO, 3'b001, 32'h7777_7777, '0, 0, 0);
    do_txn("retry", 32'h2000_0100, 1'b0, 32'h0, 4'hF, 2, 3'b100, 32'h5555_AAAA, '0, 0, 0);
    do_txn("priority", 32'h2000_0040, 1'b0, 32'h0, 4'hF, 0, 3'b011, 32'hFEED_0001, 3'b001, 0, 0);
    test_abort();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
